mini_alu_seq: RTL and testbench
===============================

Name: mini_alu_seq

Overview:
- Multi-cycle, parametrised successor to the combinational mini ALU.
- Adds, subtracts or multiplies two WIDTH-bit operands, signed or unsigned, using a shift-add multiplier.
- Converts the result magnitude to packed BCD for the seven-segment display path, with a separate negative flag.
- Uses valid/ready handshakes on both sides so it can sit between the switch/control front end and the display driver.

Parameters:
- WIDTH, 4: operand width in bits (2..16).
- DIGITS, 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^(2*WIDTH); this is checked by an elaboration-time assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands and opcode are valid
- in_ready  out  1  block can accept a new operation
- op1  in  WIDTH  operand A
- op2  in  WIDTH  operand B
- ope  in  2  opcode: 0 ADD, 1 SUB (A-B), 2 MUL, 3 reserved
- sign  in  1  1 means operands are two's complement, 0 means unsigned
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- res  out  4*DIGITS  BCD magnitude, digit 0 in res[3:0]
- neg  out  1  result is negative
- err  out  1  reserved opcode was received

Behaviour:
- Reset: one clk edge with rst_n=0 forces state IDLE. At that point in_ready=1, out_valid=0, res=0, neg=0, err=0. Any in-flight operation is discarded, including one in MUL or CONV.
- Internal binary result width is RW = 2*WIDTH. Magnitude is unsigned RW bits; sign is carried separately in neg.
- Capture (in_valid && in_ready at an edge):
  - Latch opcode.
  - If sign=1, latch |op1| and |op2| as WIDTH-bit unsigned values and record each operand's sign. -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1).
  - If sign=0, latch the raw operands with sign bits 0.
- States:
  - IDLE: in_ready=1. On capture go to EXEC for ADD/SUB, MUL for MUL, DONE with err=1 and res=0 for op 3.
  - EXEC: one cycle. Forms the signed (RW+1)-bit sum or difference from the reconstructed operand values, then stores magnitude and neg. An unsigned subtraction that underflows gives neg=1. Next state CONV.
  - MUL: exactly WIDTH cycles, one multiplier bit per cycle, LSB first, shift-add into an RW-bit accumulator. neg = sign_a XOR sign_b, forced to 0 when the product is 0. Next state CONV.
  - CONV: exactly RW cycles of serial double-dabble in the sub-module. Next state DONE.
  - DONE: out_valid=1. res, neg and err are held stable until out_valid && out_ready at an edge, then return to IDLE.
- in_ready=1 only in IDLE. There is no overlap of operations and no input buffering.
- Latency from the capture edge to out_valid high:
  - ADD/SUB: RW+2 edges (10 at WIDTH=4).
  - MUL: WIDTH+RW+1 edges (13 at WIDTH=4).
  - Reserved op: 1 edge.
- res, neg and err update only on entry to DONE. They keep their last values in IDLE and while busy; out_valid qualifies them.
- Zero result always gives neg=0. There is no negative zero.
- out_ready held high at DONE entry completes the handshake on the next edge. in_valid that is asserted while busy is ignored; the producer must hold it until it sees in_ready.
- err clears on the next captured legal operation's DONE.

Decomposition:
- Package mini_alu_pkg holds:
  - op_e enum {OP_ADD, OP_SUB, OP_MUL, OP_RSV}
  - state_e enum {IDLE, EXEC, MUL, CONV, DONE}
  - a function computing RW from WIDTH
- Sub-module bin2bcd_seq #(BIN_W, DIGITS): serial double-dabble.
  - Ports: clk, rst_n, start, bin, busy, done (1-cycle pulse), bcd.
  - start to done takes exactly BIN_W cycles.
  - Instantiated once; the top FSM holds in CONV until done.

Test Plan:
- Unsigned ADD, op1=4'b0001, op2=4'b0001, sign=0 -> out_valid 10 cycles after capture; res=20'h00002, neg=0, err=0.
- Signed and unsigned SUB:
  - op1=2, op2=1, ope=1, sign=1 -> res=20'h00001, neg=0.
  - op1=1, op2=2, ope=1, sign=0 -> res=20'h00001, neg=1.
- MUL:
  - op1=4'b0101, op2=4'b0010, sign=1 -> res=20'h00010, neg=0, 13 cycles.
  - op1=4'b1000, op2=4'b1000, sign=1 -> res=20'h00064, neg=0.
  - op1=4'hF, op2=4'hF, sign=0 -> res=20'h00225.
  - op1=4'hF(-1), op2=3, sign=1 -> res=20'h00003, neg=1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> res, neg and out_valid stable and in_ready=0; pulse a new in_valid meanwhile -> ignored. Release out_ready -> IDLE next edge.
- Reset mid-operation: assert rst_n=0 for one edge during MUL cycle 2 -> next cycle in_ready=1, out_valid=0, res=0. A following 3+4 ADD yields res=20'h00007.
- ope=3 -> out_valid one edge after capture with err=1, res=0. A following ADD 1+1 returns err=0.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// rtl/mini_alu_pkg.sv - shared opcode/state types and sizing helpers for mini_alu_seq
package mini_alu_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSV} op_e;

    typedef enum logic [2:0] {IDLE, EXEC, MUL, CONV, DONE} state_e;

    function automatic int calc_rw(input int width);
        return 2 * width;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/mini_alu_seq_if.sv
// rtl/mini_alu_seq_if.sv - operand/result handshake bundle for mini_alu_seq
interface mini_alu_seq_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      op1;
    logic [WIDTH-1:0]      op2;
    logic [1:0]            ope;
    logic                  sign;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   res;
    logic                  neg;
    logic                  err;

    modport master (
        output in_valid, op1, op2, ope, sign, out_ready,
        input  in_ready, out_valid, res, neg, err
    );

    modport slave (
        input  in_valid, op1, op2, ope, sign, out_ready,
        output in_ready, out_valid, res, neg, err
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - serial double-dabble, one bit per cycle, first step on the start cycle
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;

    logic [BIN_W-1:0]    w_src_bin;
    logic [4*DIGITS-1:0] w_src_bcd;
    logic [4*DIGITS-1:0] w_adj;
    logic [BIN_W-1:0]    w_next_bin;
    logic [4*DIGITS-1:0] w_next_bcd;

    // The start cycle consumes the new word directly so the whole job fits in BIN_W cycles.
    always_comb begin
        w_src_bin = start ? bin : r_bin;
        w_src_bcd = start ? '0 : r_bcd;
        w_adj     = w_src_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_src_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = w_src_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_next_bin = w_src_bin << 1;
        w_next_bcd = {w_adj[4*DIGITS-2:0], w_src_bin[BIN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin  <= w_next_bin;
                r_bcd  <= w_next_bcd;
                r_cnt  <= CW'(BIN_W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bin <= w_next_bin;
                r_bcd <= w_next_bcd;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: rtl/mini_alu_seq.sv
// rtl/mini_alu_seq.sv - multi-cycle add/sub/shift-add-multiply ALU with serial BCD result
module mini_alu_seq
    import mini_alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mini_alu_seq_if.slave  bus
);
    localparam int RW  = calc_rw(WIDTH);
    localparam int MCW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("mini_alu_seq: WIDTH must be in 2..16");
    end
    if (pow10(DIGITS) <= (64'd1 << RW)) begin : g_bad_digits
        $error("mini_alu_seq: DIGITS too small for a 2*WIDTH-bit magnitude");
    end

    state_e              r_state;
    op_e                 r_op;
    logic [RW-1:0]       r_mcand;
    logic [RW-1:0]       r_acc;
    logic [WIDTH-1:0]    r_mplier;
    logic [MCW-1:0]      r_mcnt;
    logic                r_sa;
    logic                r_sb;
    logic                r_neg_tmp;
    logic [4*DIGITS-1:0] r_res;
    logic                r_neg;
    logic                r_err;
    logic                r_in_ready;
    logic                r_out_valid;

    logic                w_sa;
    logic                w_sb;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [RW:0]         w_va;
    logic [RW:0]         w_vb;
    logic [RW:0]         w_sum;
    logic [RW:0]         w_sum_neg;
    logic [RW-1:0]       w_mag;
    logic [RW-1:0]       w_acc_next;
    logic                w_mul_last;
    logic                w_start;
    logic [RW-1:0]       w_bin;
    logic                w_busy;
    logic                w_done;
    logic [4*DIGITS-1:0] w_bcd;

    assign w_sa    = bus.sign & bus.op1[WIDTH-1];
    assign w_sb    = bus.sign & bus.op2[WIDTH-1];
    assign w_abs_a = w_sa ? -bus.op1 : bus.op1;
    assign w_abs_b = w_sb ? -bus.op2 : bus.op2;

    // Magnitudes stay below 2^RW, so an RW+1-bit two's complement sum never overflows.
    assign w_va      = r_sa ? -{1'b0, r_mcand} : {1'b0, r_mcand};
    assign w_vb      = r_sb ? -{{(RW+1-WIDTH){1'b0}}, r_mplier} : {{(RW+1-WIDTH){1'b0}}, r_mplier};
    assign w_sum     = (r_op == OP_SUB) ? (w_va - w_vb) : (w_va + w_vb);
    assign w_sum_neg = -w_sum;
    assign w_mag     = w_sum[RW] ? w_sum_neg[RW-1:0] : w_sum[RW-1:0];

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_state == MUL) && (r_mcnt == MCW'(1));

    // Converter is kicked off from the final compute cycle so CONV lasts exactly RW cycles.
    assign w_start = !w_busy && ((r_state == EXEC) || w_mul_last);
    assign w_bin   = (r_state == EXEC) ? w_mag : w_acc_next;

    bin2bcd_seq #(
        .BIN_W  (RW),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (w_bin),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_mcnt      <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_neg_tmp   <= 1'b0;
            r_res       <= '0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= op_e'(bus.ope);
                        r_mcand    <= RW'(w_abs_a);
                        r_mplier   <= w_abs_b;
                        r_sa       <= w_sa;
                        r_sb       <= w_sb;
                        r_acc      <= '0;
                        r_mcnt     <= MCW'(WIDTH);
                        r_in_ready <= 1'b0;
                        case (op_e'(bus.ope))
                            OP_MUL: r_state <= MUL;
                            OP_RSV: begin
                                r_state     <= DONE;
                                r_res       <= '0;
                                r_neg       <= 1'b0;
                                r_err       <= 1'b1;
                                r_out_valid <= 1'b1;
                            end
                            default: r_state <= EXEC;
                        endcase
                    end
                end
                EXEC: begin
                    r_neg_tmp <= w_sum[RW];
                    r_state   <= CONV;
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_mcnt   <= r_mcnt - MCW'(1);
                    if (w_mul_last) begin
                        r_neg_tmp <= (r_sa ^ r_sb) && (w_acc_next != '0);
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    if (w_done) begin
                        r_state     <= DONE;
                        r_res       <= w_bcd;
                        r_neg       <= r_neg_tmp;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.neg       = r_neg;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_mini_alu_seq.sv
// tb/tb_mini_alu_seq.sv - directed and random self-checking bench for mini_alu_seq
module tb_mini_alu_seq;
    localparam int W = 4;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mini_alu_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    mini_alu_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, decimal digits by repeated division.
    task automatic model(input int a, input int b, input int op, input int sg,
                         output logic [19:0] res, output logic ng, output logic er, output int lat);
        int va, vb, r, m;
        va = (sg != 0 && ((a >> (W-1)) & 1) != 0) ? a - (1 << W) : a;
        vb = (sg != 0 && ((b >> (W-1)) & 1) != 0) ? b - (1 << W) : b;
        er = 1'b0;
        case (op)
            0: begin r = va + vb; lat = 2*W + 2; end
            1: begin r = va - vb; lat = 2*W + 2; end
            2: begin r = va * vb; lat = W + 2*W + 1; end
            default: begin r = 0; lat = 1; er = 1'b1; end
        endcase
        ng = (r < 0);
        m  = (r < 0) ? -r : r;
        res = '0;
        for (int i = 0; i < D; i++) begin
            res[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endtask

    task automatic issue(input int a, input int b, input int op, input int sg);
        int n;
        @(negedge clk);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.op1      = W'(a);
        bus.op2      = W'(b);
        bus.ope      = 2'(op);
        bus.sign     = 1'(sg);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int a, input int b, input int op, input int sg, input string tag);
        logic [19:0] er;
        logic en, ee;
        int lat, n;
        model(a, b, op, sg, er, en, ee, lat);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_res"}, 32'(bus.res), 32'(er));
        check({tag, "_neg"}, 32'(bus.neg), 32'(en));
        check({tag, "_err"}, 32'(bus.err), 32'(ee));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ack_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_ack_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic do_op(input int a, input int b, input int op, input int sg, input string tag);
        issue(a, b, op, sg);
        wait_result(a, b, op, sg, tag);
        ack(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] held;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op1 = '0; bus.op2 = '0; bus.ope = '0; bus.sign = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_res", 32'(bus.res), 32'd0);
        check("rst_neg", 32'(bus.neg), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        do_op(1, 1, 0, 0, "add_1_1");
        do_op(2, 1, 1, 1, "sub_s_2_1");
        do_op(1, 2, 1, 0, "sub_u_1_2");
        do_op(5, 2, 2, 1, "mul_5_2");
        do_op(8, 8, 2, 1, "mul_m8_m8");
        do_op(15, 15, 2, 0, "mul_15_15");
        do_op(15, 3, 2, 1, "mul_m1_3");
        do_op(0, 9, 2, 1, "mul_zero_neg");
        do_op(8, 7, 1, 1, "sub_m8_7");
        do_op(3, 3, 1, 1, "sub_zero");

        // Backpressure: result must hold while the consumer stalls; stray in_valid is ignored.
        issue(6, 7, 2, 0);
        wait_result(6, 7, 2, 0, "bp");
        held = bus.res;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 5);
            bus.op1 = 4'd1; bus.op2 = 4'd1; bus.ope = 2'd0; bus.sign = 1'b0;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_res", 32'(bus.res), 32'h00042);
            check("bp_res_stable", 32'(bus.res), 32'(held));
            check("bp_neg", 32'(bus.neg), 32'd0);
        end
        ack("bp");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_no_ghost_ov", 32'(bus.out_valid), 32'd0);
            check("bp_no_ghost_ir", 32'(bus.in_ready), 32'd1);
        end

        // Reset during the second multiply cycle.
        issue(7, 7, 2, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_res", 32'(bus.res), 32'd0);
        repeat (20) begin
            @(posedge clk);
            #1;
            check("midrst_quiet", 32'(bus.out_valid), 32'd0);
        end
        do_op(3, 4, 0, 0, "add_3_4");

        do_op(5, 6, 3, 0, "rsv");
        do_op(1, 1, 0, 0, "add_after_rsv");

        for (int k = 0; k < 40; k++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
